// File: rtl/fcp_pkg.sv
// Shared encodings for the FCP burst master: lane control codes, FSM states,
// and the header bit that selects read versus write.
package fcp_pkg;

    typedef enum logic [1:0] {
        CTRL_IDLE = 2'b00,
        CTRL_HDR  = 2'b01,
        CTRL_DATA = 2'b10,
        CTRL_END  = 2'b11
    } ctrl_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_WDATA,
        S_END,
        S_RDATA,
        S_WAIT_ACK
    } state_e;

    localparam int HDR_RD_BIT = 7;

    function automatic ctrl_e ctrl_of(input state_e s);
        case (s)
            S_HDR:   return CTRL_HDR;
            S_WDATA: return CTRL_DATA;
            S_END:   return CTRL_END;
            default: return CTRL_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/fcp_lane_shifter.sv
// 8-bit load/shift register shared by the serialiser (MSB out first) and the
// deserialiser (new lane bits enter at the LSB end).
module fcp_lane_shifter #(
    parameter int LANE_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift_en,
    input  logic [7:0]        din,
    input  logic [LANE_W-1:0] lane_in,
    output logic [LANE_W-1:0] lane_out,
    output logic [7:0]        dout
);

    logic [7:0] sh_q, sh_d;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        sh_d = sh_q;
        if (load) begin
            sh_d = din;
        end else if (shift_en) begin
            sh_d = (sh_q << LANE_W) | 8'(lane_in);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sh_q <= '0;
        else     sh_q <= sh_d;
    end

    assign lane_out = sh_q[7 -: LANE_W];
    assign dout     = sh_q;

endmodule

// File: rtl/fcp_burst_master.sv
// FCP lane master: header plus 1..MAX_BURST byte burst, ack wait with timeout,
// bounded replay of the latched command, and single-cycle done/err pulses.
module fcp_burst_master
    import fcp_pkg::*;
#(
    parameter int LANE_W      = 2,
    parameter int MAX_BURST   = 4,
    parameter int ACK_TIMEOUT = 16,
    parameter int RETRIES     = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [7:0]                   header_in,
    input  logic [$clog2(MAX_BURST+1)-1:0] len_in,
    input  logic [8*MAX_BURST-1:0]       wdata_in,
    output logic [LANE_W-1:0]            data,
    output logic [1:0]                   ctrl,
    input  logic [LANE_W-1:0]            s_data,
    input  logic                         s_valid,
    input  logic                         ack,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [8*MAX_BURST-1:0]       read_data
);

    localparam int BPB    = 8 / LANE_W;
    localparam int BPB_SH = $clog2(BPB);
    localparam int BEAT_W = $clog2(MAX_BURST * 8 / LANE_W + 1);
    localparam int LEN_W  = $clog2(MAX_BURST + 1);
    localparam int IDX_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int ATT_W  = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
    localparam int TMR_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [BEAT_W-1:0] BYTE_LAST = BEAT_W'(BPB - 1);

    state_e                 state_q, state_d;
    ctrl_e                  ctrl_q, ctrl_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [ATT_W-1:0]       attempt_q, attempt_d;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [7:0]             hdr_q, hdr_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [8*MAX_BURST-1:0] wdata_q, wdata_d, rd_buf_q, rd_buf_d, read_data_q, read_data_d;
    logic                   busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic              sh_load, sh_shift;
    logic [7:0]        sh_din, sh_dout, rx_byte, nxt_byte;
    logic [LANE_W-1:0] lane_out;
    logic [BEAT_W-1:0] total_beats;
    logic [IDX_W-1:0]  cur_idx, nxt_idx;
    logic              is_rd, byte_last, rx_full;

    fcp_lane_shifter #(.LANE_W(LANE_W)) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (sh_load),
        .shift_en (sh_shift),
        .din      (sh_din),
        .lane_in  (s_data),
        .lane_out (lane_out),
        .dout     (sh_dout)
    );

    always_comb begin
        is_rd       = hdr_q[HDR_RD_BIT];
        total_beats = BEAT_W'(len_q) * BEAT_W'(BPB);
        byte_last   = (beat_q & BYTE_LAST) == BYTE_LAST;
        rx_full     = beat_q == total_beats;
        cur_idx     = IDX_W'(beat_q >> BPB_SH);
        nxt_idx     = cur_idx + IDX_W'(1);
        rx_byte     = (sh_dout << LANE_W) | 8'(s_data);
        nxt_byte    = wdata_q[7:0];
        for (int b = 0; b < MAX_BURST; b++) begin
            if (nxt_idx == IDX_W'(b)) nxt_byte = wdata_q[8*b +: 8];
        end

        state_d     = state_q;
        beat_d      = beat_q;
        attempt_d   = attempt_q;
        timer_d     = timer_q;
        hdr_d       = hdr_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        rd_buf_d    = rd_buf_q;
        read_data_d = read_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        sh_load     = 1'b0;
        sh_shift    = 1'b0;
        sh_din      = hdr_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    hdr_d     = header_in;
                    len_d     = (len_in == '0 || len_in > LEN_W'(MAX_BURST)) ? LEN_W'(1) : len_in;
                    wdata_d   = wdata_in;
                    attempt_d = '0;
                    rd_buf_d  = '0;
                    beat_d    = '0;
                    busy_d    = 1'b1;
                    state_d   = S_HDR;
                    sh_load   = 1'b1;
                    sh_din    = header_in;
                end
            end
            S_HDR: begin
                sh_shift = 1'b1;
                beat_d   = beat_q + BEAT_W'(1);
                if (beat_q == BYTE_LAST) begin
                    beat_d  = '0;
                    state_d = is_rd ? S_END : S_WDATA;
                    sh_load = 1'b1;
                    sh_din  = wdata_q[7:0];
                end
            end
            S_WDATA: begin
                sh_shift = 1'b1;
                beat_d   = beat_q + BEAT_W'(1);
                if (byte_last) begin
                    if (beat_q == total_beats - BEAT_W'(1)) begin
                        beat_d  = '0;
                        state_d = S_END;
                    end else begin
                        sh_load = 1'b1;
                        sh_din  = nxt_byte;
                    end
                end
            end
            S_END: begin
                beat_d  = '0;
                timer_d = '0;
                state_d = is_rd ? S_RDATA : S_WAIT_ACK;
            end
            S_RDATA, S_WAIT_ACK: begin
                timer_d = s_valid ? '0 : timer_q + TMR_W'(1);
                if (state_q == S_RDATA && s_valid && !rx_full) begin
                    sh_shift = 1'b1;
                    beat_d   = beat_q + BEAT_W'(1);
                    if (byte_last) begin
                        for (int b = 0; b < MAX_BURST; b++) begin
                            if (cur_idx == IDX_W'(b)) rd_buf_d[8*b +: 8] = rx_byte;
                        end
                    end
                end
                // A read only accepts ack once every requested beat has arrived.
                if (ack && (state_q == S_WAIT_ACK || rx_full)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (state_q == S_RDATA) read_data_d = rd_buf_q;
                end else if (!s_valid && timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                    if (attempt_q < ATT_W'(RETRIES)) begin
                        attempt_d = attempt_q + ATT_W'(1);
                        state_d   = S_HDR;
                        beat_d    = '0;
                        timer_d   = '0;
                        rd_buf_d  = '0;
                        sh_load   = 1'b1;
                        sh_din    = hdr_q;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        ctrl_d = ctrl_of(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ctrl_q      <= CTRL_IDLE;
            beat_q      <= '0;
            attempt_q   <= '0;
            timer_q     <= '0;
            hdr_q       <= '0;
            len_q       <= '0;
            wdata_q     <= '0;
            rd_buf_q    <= '0;
            read_data_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            beat_q      <= beat_d;
            attempt_q   <= attempt_d;
            timer_q     <= timer_d;
            hdr_q       <= hdr_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            rd_buf_q    <= rd_buf_d;
            read_data_q <= read_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // The lane only carries shifter bits while header or write data is on the wire.
    assign data      = (state_q == S_HDR || state_q == S_WDATA) ? lane_out : '0;
    assign ctrl      = ctrl_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign read_data = read_data_q;

endmodule
